// File: rtl/test_cam.sv
// OV7670-class capture (RGB565 byte pairs -> RGB444) into a 160x120 buffer, read out on 640x480@60 VGA.
// Define UPSCALE_X4_EN to replicate each stored pixel 4x4 over the full visible area.
module test_cam #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic       clk,
  input  logic       rst,
  output logic       VGA_Hsync_n,
  output logic       VGA_Vsync_n,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       CAM_xclk,
  output logic       CAM_pwdn,
  output logic       CAM_reset,
  input  logic       CAM_PCLK,
  input  logic       CAM_HREF,
  input  logic       CAM_VSYNC,
  input  logic [7:0] CAM_px_data
);
  localparam int              NPIX   = IMG_W * IMG_H;
  localparam logic [AW-1:0]   CAP    = AW'(NPIX);
  localparam logic [9:0]      H_VIS  = 10'd640;
  localparam logic [9:0]      H_SS   = 10'd656;
  localparam logic [9:0]      H_SE   = 10'd752;
  localparam logic [9:0]      H_LAST = 10'd799;
  localparam logic [9:0]      V_VIS  = 10'd480;
  localparam logic [9:0]      V_SS   = 10'd490;
  localparam logic [9:0]      V_SE   = 10'd492;
  localparam logic [9:0]      V_LAST = 10'd524;
  localparam logic [9:0]      WIN_W  = 10'(IMG_W);
  localparam logic [9:0]      WIN_H  = 10'(IMG_H);

  typedef enum logic [1:0] {WAIT_FRAME, BYTE1, BYTE2} cap_st_t;

  // clock divider: xclk is div[1] (period 4), pe fires on the last phase
  logic [1:0] div;
  logic       pe;

  always_ff @(posedge clk or negedge rst)
    if (!rst) div <= '0;
    else      div <= div + 2'd1;

  assign pe        = (div == 2'd3);
  assign CAM_xclk  = div[1];
  assign CAM_pwdn  = 1'b0;
  assign CAM_reset = 1'b1;

  // camera synchronisers; edge, strobes and data all come from stage [1]
  logic [1:0]      pclk_s, href_s, vs_s;
  logic [1:0][7:0] dat_s;
  logic            pclk_q;
  logic            pclk_rise, href, vsync;
  logic [7:0]      data;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pclk_s <= '0;
      href_s <= '0;
      vs_s   <= '0;
      dat_s  <= '0;
      pclk_q <= 1'b0;
    end else begin
      pclk_s <= {pclk_s[0], CAM_PCLK};
      href_s <= {href_s[0], CAM_HREF};
      vs_s   <= {vs_s[0], CAM_VSYNC};
      dat_s  <= {dat_s[0], CAM_px_data};
      pclk_q <= pclk_s[1];
    end

  assign pclk_rise = pclk_s[1] & ~pclk_q;
  assign href      = href_s[1];
  assign vsync     = vs_s[1];
  assign data      = dat_s[1];

  // capture FSM
  cap_st_t        st;
  logic           vs_seen;
  logic [7:0]     hi;
  logic [AW-1:0]  addr, waddr;
  logic [11:0]    wdata;
  logic           we;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st      <= WAIT_FRAME;
      vs_seen <= 1'b0;
      hi      <= '0;
      addr    <= '0;
      waddr   <= '0;
      wdata   <= '0;
      we      <= 1'b0;
    end else begin
      we <= 1'b0;
      if (pclk_rise) begin
        if (vsync) begin
          st      <= WAIT_FRAME;
          vs_seen <= 1'b1;
          addr    <= '0;
        end else begin
          case (st)
            WAIT_FRAME: if (vs_seen) begin
              st      <= BYTE1;
              vs_seen <= 1'b0;
            end
            BYTE1: if (href) begin
              hi <= data;
              st <= BYTE2;
            end
            BYTE2: begin
              st <= BYTE1;
              // address saturates at the frame size so overlong frames never wrap
              if (href && addr < CAP) begin
                we    <= 1'b1;
                waddr <= addr;
                wdata <= {hi[7:4], hi[2:0], data[7], data[4:1]};
                addr  <= addr + AW'(1);
              end
            end
            default: st <= WAIT_FRAME;
          endcase
        end
      end
    end

  // frame buffer: read-before-write on a same-cycle collision
  logic [11:0]   fb [NPIX];
  logic [11:0]   rd_data;
  logic [AW-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (we) fb[waddr] <= wdata;
    rd_data <= fb[rd_addr];
  end

  // VGA raster
  logic [9:0] hcnt, vcnt;
  logic       vis, in_win;

  always_comb begin
    vis = (hcnt < H_VIS) && (vcnt < V_VIS);
`ifdef UPSCALE_X4_EN
    in_win  = vis;
    rd_addr = AW'(vcnt >> 2) * AW'(IMG_W) + AW'(hcnt >> 2);
`else
    in_win  = (hcnt < WIN_W) && (vcnt < WIN_H);
    rd_addr = AW'(vcnt) * AW'(IMG_W) + AW'(hcnt);
`endif
    if (!in_win) rd_addr = '0;
  end

  // outputs for a raster position are registered on the pe after it was addressed
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      VGA_Hsync_n <= 1'b1;
      VGA_Vsync_n <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pe) begin
      VGA_Hsync_n <= !(hcnt >= H_SS && hcnt < H_SE);
      VGA_Vsync_n <= !(vcnt >= V_SS && vcnt < V_SE);
      {VGA_R, VGA_G, VGA_B} <= (vis && in_win) ? rd_data : 12'h000;
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end

endmodule

// File: tb/tb_test_cam.sv
// Scoreboard bench for test_cam on a reduced 16x8 image; VGA timing kept at full size.
module tb_test_cam;
  localparam int IMG_W = 16;
  localparam int IMG_H = 8;
  localparam int AW    = 15;
  localparam int CAP   = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hs, vs, xclk, pwdn, creset;
  logic [3:0] r, g, b;
  logic       pclk = 1'b0, href = 1'b0, vsync = 1'b0;
  logic [7:0] pxd = 8'h00;

  always #5 clk = ~clk;

  test_cam #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .VGA_Hsync_n(hs), .VGA_Vsync_n(vs),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .CAM_xclk(xclk), .CAM_pwdn(pwdn), .CAM_reset(creset),
    .CAM_PCLK(pclk), .CAM_HREF(href), .CAM_VSYNC(vsync), .CAM_px_data(pxd)
  );

  int total = 0, bad = 0, cyc = 0, wr_cnt = 0;
  bit done = 1'b0;

  always @(posedge clk) if (rst) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // camera-side model and write scoreboard
  bit          m_armed = 0, m_inframe = 0, m_half = 0;
  logic [7:0]  m_hi;
  int          m_addr = 0;
  logic [11:0] fb_model [CAP];
  logic [31:0] sb [$];

  task automatic send_byte(input logic v, input logic h, input logic [7:0] d);
    logic [11:0] px;
    if (v) begin
      m_armed = 1; m_inframe = 0; m_half = 0; m_addr = 0;
    end else if (!m_inframe) begin
      m_half = 0;
      if (m_armed) begin m_inframe = 1; m_armed = 0; end
    end else if (!h) begin
      m_half = 0;
    end else if (!m_half) begin
      m_hi = d; m_half = 1;
    end else begin
      m_half = 0;
      if (m_addr < CAP) begin
        px = {m_hi[7:4], m_hi[2:0], d[7], d[4:1]};
        fb_model[m_addr] = px;
        sb.push_back(32'({AW'(m_addr), px}));
        m_addr++;
      end
    end
    @(negedge clk); vsync = v; href = h; pxd = d; pclk = 1'b0;
    @(negedge clk); @(negedge clk); pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_vs();
    repeat (2 * (2 * IMG_W + 4)) send_byte(1'b1, 1'b0, 8'h00);
    repeat (4) send_byte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nb, input bit rnd);
    for (int i = 0; i < nb; i++) send_byte(1'b0, 1'b1, rnd ? 8'($urandom) : 8'hE0);
    repeat (4) send_byte(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    wait (rst === 1'b1);
    forever begin
      @(posedge clk); #1;
      if (dut.we) begin
        wr_cnt++;
        if (sb.size() == 0) chk("wr_extra", sb.size(), 1);
        else chk("wr", {dut.waddr, dut.wdata}, sb.pop_front());
      end
    end
  end

  // VGA scoreboard: expectation for raster index j is pushed one pe before it appears
  typedef struct packed { logic [1:0] sync; logic rgb_chk; logic [11:0] rgb; } vexp_t;
  vexp_t vq [$];

  function automatic vexp_t vga_exp(input int j);
    int x, y;
    vexp_t e;
    x = j % 800;
    y = (j / 800) % 525;
    e.sync    = {(x < 656 || x > 751), (y < 490 || y > 491)};
    e.rgb_chk = !(x < IMG_W && y < 2);   // rows 0-1 are read before capture completes
    e.rgb     = (x < IMG_W && y < IMG_H) ? fb_model[y * IMG_W + x] : 12'h000;
    return e;
  endfunction

  initial begin
    vexp_t e;
    int    last_fall, low_cnt;
    logic  prev_hs;
    last_fall = 0; low_cnt = 0; prev_hs = 1'b1;
    wait (rst === 1'b1);
    vq.push_back(vga_exp(0));
    while (!done) begin
      @(posedge clk); #1;
      if (cyc % 4 == 0) begin
        e = vq.pop_front();
        chk("vga_sync", {hs, vs}, e.sync);
        if (e.rgb_chk) chk("vga_rgb", {r, g, b}, e.rgb);
        if (prev_hs && !hs) begin
          if (last_fall > 0) begin
            chk("hs_period", cyc - last_fall, 3200);
            chk("hs_low", low_cnt, 96);
          end
          last_fall = cyc;
          low_cnt   = 0;
        end
        if (!hs) low_cnt++;
        prev_hs = hs;
        vq.push_back(vga_exp(cyc / 4));
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < CAP; i++) fb_model[i] = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_xclk", xclk, 0);
    chk("pwdn", pwdn, 0);
    chk("cam_reset", creset, 1);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk("xclk", xclk, (cyc % 4) >= 2);
    end

    // frame 1a: constant E0, two overlong lines hit saturation
    wr_cnt = 0;
    send_vs();
    for (int l = 0; l < IMG_H + 2; l++) send_line(2 * IMG_W, 1'b0);
    repeat (8) @(negedge clk);
    chk("f1_writes", wr_cnt, CAP);
    chk("f1_sb", sb.size(), 0);
    chk("f1_px0", dut.fb[0], 12'hE10);
    chk("f1_pxN", dut.fb[CAP-1], 12'hE10);

    // frame 1b: random data, shown on VGA rows 2..IMG_H-1
    wr_cnt = 0;
    send_vs();
    for (int l = 0; l < IMG_H; l++) send_line(2 * IMG_W, 1'b1);
    repeat (8) @(negedge clk);
    chk("f1b_writes", wr_cnt, CAP);
    chk("f1b_sb", sb.size(), 0);

    while (cyc < 3200 * IMG_H + 8) @(negedge clk);

    // frame 2: odd-length line, then VSYNC mid-line with a half pixel pending
    wr_cnt = 0;
    send_vs();
    for (int l = 0; l < 3; l++) send_line(2 * IMG_W, 1'b1);
    send_line(9, 1'b1);
    for (int i = 0; i < 11; i++) send_byte(1'b0, 1'b1, 8'($urandom));
    repeat (8) send_byte(1'b1, 1'b1, 8'($urandom));
    repeat (4) send_byte(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 2; l++) send_line(2 * IMG_W, 1'b1);
    repeat (8) @(negedge clk);
    chk("f2_writes", wr_cnt, 3 * IMG_W + 4 + 5 + 2 * IMG_W);
    chk("f2_sb", sb.size(), 0);
    chk("f2_a0", dut.fb[0], fb_model[0]);

    // frame 3: overlong frame, exactly CAP writes and no wrap
    wr_cnt = 0;
    send_vs();
    for (int l = 0; l < IMG_H + 5; l++) send_line(2 * IMG_W, 1'b1);
    repeat (8) @(negedge clk);
    chk("f3_writes", wr_cnt, CAP);
    chk("f3_sb", sb.size(), 0);
    chk("f3_last", dut.fb[CAP-1], fb_model[CAP-1]);
    chk("f3_a0", dut.fb[0], fb_model[0]);

    done = 1'b1;
    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
